// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: queues 40-bit SPI commands, issues them one at a time
// to an external SPI controller with a guaranteed idle gap between transactions,
// optionally captures readback words into a small FIFO, and flags controller
// timeouts and lost readback words with sticky error bits.
module spi_cmd_sequencer #(
    parameter int CMD_DEPTH  = 4,
    parameter int RD_DEPTH   = 2,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [39:0] cmd_data,
    input  logic        cmd_is_dac,
    input  logic        cmd_rd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [39:0] spi_data_in,
    output logic        spi_trigger_sys,
    output logic        spi_trigger_dac,
    input  logic        spi_done,
    input  logic        spi_wr_en,
    input  logic [39:0] spi_data_out,
    output logic [39:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        busy,
    output logic        timeout_err,
    output logic        rd_lost_err,
    input  logic        err_clr
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RD_DEPTH);
    localparam logic [CAW:0] CMD_ONE      = 1;
    localparam logic [RAW:0] RD_ONE       = 1;
    localparam logic [7:0]   TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0]   GAP_LAST     = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        WAIT_WR,
        GAP
    } state_t;

    // Command FIFO storage: {is_dac, rd, data}; pointers carry one extra wrap bit
    logic [41:0]  cmdMem_q [CMD_DEPTH];
    logic [CAW:0] cmdWrPtr_q, cmdRdPtr_q;
    logic         cmdEmpty, cmdFull, cmdPush, cmdPop;
    logic [41:0]  cmdHead;

    // Readback FIFO storage
    logic [39:0]  rdMem_q [RD_DEPTH];
    logic [RAW:0] rdWrPtr_q, rdRdPtr_q;
    logic         rdEmpty, rdFull, rdPush, rdPop, rdLost;

    // Sequencer state
    state_t       state_q, state_d;
    logic [39:0]  spiData_q;
    logic         isDac_q, isRd_q;
    logic [7:0]   timer_q, timer_d;
    logic [3:0]   gap_q, gap_d;
    logic         readyEn_q;
    logic         timeoutErr_q, timeoutErr_d;
    logic         rdLostErr_q, rdLostErr_d;
    logic         loadCmd, capture, timeoutHit;

    assign cmdEmpty  = (cmdWrPtr_q == cmdRdPtr_q);
    assign cmdFull   = (cmdWrPtr_q[CAW] != cmdRdPtr_q[CAW]) &&
                       (cmdWrPtr_q[CAW-1:0] == cmdRdPtr_q[CAW-1:0]);
    assign cmdHead   = cmdMem_q[cmdRdPtr_q[CAW-1:0]];
    assign cmd_ready = readyEn_q && !cmdFull;
    assign cmdPush   = cmd_valid && cmd_ready;

    assign rdEmpty  = (rdWrPtr_q == rdRdPtr_q);
    assign rdFull   = (rdWrPtr_q[RAW] != rdRdPtr_q[RAW]) &&
                      (rdWrPtr_q[RAW-1:0] == rdRdPtr_q[RAW-1:0]);
    assign rd_valid = !rdEmpty;
    assign rd_data  = rdMem_q[rdRdPtr_q[RAW-1:0]];
    assign rdPop    = rd_valid && rd_ready;
    // A full FIFO can still take a word when the head leaves in the same cycle
    assign rdPush   = capture && isRd_q && (!rdFull || rdPop);
    assign rdLost   = capture && isRd_q && rdFull && !rdPop;

    assign spi_data_in     = spiData_q;
    assign spi_trigger_dac = (state_q == ISSUE) && isDac_q;
    assign spi_trigger_sys = (state_q == ISSUE) && !isDac_q;
    assign busy            = (state_q != IDLE);
    assign timeout_err     = timeoutErr_q;
    assign rd_lost_err     = rdLostErr_q;

    // Command FIFO: write on accepted handshake, advance read pointer on ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmdWrPtr_q <= '0;
            cmdRdPtr_q <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) begin
                cmdMem_q[i] <= '0;
            end
        end else begin
            if (cmdPush) begin
                cmdMem_q[cmdWrPtr_q[CAW-1:0]] <= {cmd_is_dac, cmd_rd, cmd_data};
                cmdWrPtr_q <= cmdWrPtr_q + CMD_ONE;
            end
            if (cmdPop) begin
                cmdRdPtr_q <= cmdRdPtr_q + CMD_ONE;
            end
        end
    end

    // Readback FIFO: capture controller words, release on consumer handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdWrPtr_q <= '0;
            rdRdPtr_q <= '0;
            for (int i = 0; i < RD_DEPTH; i++) begin
                rdMem_q[i] <= '0;
            end
        end else begin
            if (rdPush) begin
                rdMem_q[rdWrPtr_q[RAW-1:0]] <= spi_data_out;
                rdWrPtr_q <= rdWrPtr_q + RD_ONE;
            end
            if (rdPop) begin
                rdRdPtr_q <= rdRdPtr_q + RD_ONE;
            end
        end
    end

    // Next-state logic for the transaction sequencer
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        loadCmd    = 1'b0;
        cmdPop     = 1'b0;
        capture    = 1'b0;
        timeoutHit = 1'b0;
        case (state_q)
            IDLE: begin
                // A readback command is held back until there is room for its word
                if (!cmdEmpty && !(cmdHead[40] && rdFull)) begin
                    loadCmd = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cmdPop  = 1'b1;
                timer_d = 8'd1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                timer_d = timer_q + 8'd1;
                if (spi_done && spi_wr_en) begin
                    capture = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end else if (spi_done) begin
                    state_d = WAIT_WR;
                end else if (timer_q >= TIMEOUT_LAST) begin
                    timeoutHit = 1'b1;
                    gap_d      = '0;
                    state_d    = GAP;
                end
            end
            WAIT_WR: begin
                timer_d = timer_q + 8'd1;
                if (spi_wr_en) begin
                    capture = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end else if (timer_q >= TIMEOUT_LAST) begin
                    timeoutHit = 1'b1;
                    gap_d      = '0;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky error flags: a new error in the same cycle beats a clear
    always_comb begin
        timeoutErr_d = timeoutErr_q;
        rdLostErr_d  = rdLostErr_q;
        if (err_clr) begin
            timeoutErr_d = 1'b0;
            rdLostErr_d  = 1'b0;
        end
        if (timeoutHit) begin
            timeoutErr_d = 1'b1;
        end
        if (rdLost) begin
            rdLostErr_d = 1'b1;
        end
    end

    // Sequencer registers; the SPI word is latched on the way into ISSUE and held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            spiData_q    <= '0;
            isDac_q      <= 1'b0;
            isRd_q       <= 1'b0;
            timer_q      <= '0;
            gap_q        <= '0;
            readyEn_q    <= 1'b0;
            timeoutErr_q <= 1'b0;
            rdLostErr_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            gap_q        <= gap_d;
            readyEn_q    <= 1'b1;
            timeoutErr_q <= timeoutErr_d;
            rdLostErr_q  <= rdLostErr_d;
            if (loadCmd) begin
                spiData_q <= cmdHead[39:0];
                isDac_q   <= cmdHead[41];
                isRd_q    <= cmdHead[40];
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: commands push expected triggers and
// readback words into queues, independent monitors pop and compare them, and
// a behavioural SPI controller answers each trigger after a fixed latency.
module tb_spi_cmd_sequencer;

   localparam int CMD_DEPTH   = 4;
   localparam int RD_DEPTH    = 2;
   localparam int GAP_CYCLES  = 2;
   localparam int TIMEOUT     = 64;
   localparam int CTL_LAT     = 40;
   localparam int MIN_SPACING = CTL_LAT + GAP_CYCLES + 1;

   logic        clk;
   logic        rst_n;
   logic [39:0] cmd_data;
   logic        cmd_is_dac;
   logic        cmd_rd;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [39:0] spi_data_in;
   logic        spi_trigger_sys;
   logic        spi_trigger_dac;
   logic        spi_done;
   logic        spi_wr_en;
   logic [39:0] spi_data_out;
   logic [39:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic        busy;
   logic        timeout_err;
   logic        rd_lost_err;
   logic        err_clr;

   int total = 0;
   int bad = 0;
   int cycleCnt = 0;
   int trigCount = 0;
   int lastTrigCycle = 0;
   bit hasPrev = 0;

   logic [40:0] expTrigQ[$];
   logic [39:0] expRdQ[$];
   logic [39:0] ctlRespQ[$];

   bit          ctlNoDone = 0;
   bit          ctlSame = 0;
   int          strayReq = 0;
   int          strayAck = 0;
   bit          ctlActive = 0;
   int          ctlCnt = 0;
   bit          ctlNoDoneLat = 0;
   bit          ctlSameLat = 0;
   logic [39:0] ctlResp = '0;
   logic [39:0] ctlHeld = '0;

   spi_cmd_sequencer #(
      .CMD_DEPTH(CMD_DEPTH),
      .RD_DEPTH(RD_DEPTH),
      .GAP_CYCLES(GAP_CYCLES),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cmd_data(cmd_data),
      .cmd_is_dac(cmd_is_dac),
      .cmd_rd(cmd_rd),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .spi_data_in(spi_data_in),
      .spi_trigger_sys(spi_trigger_sys),
      .spi_trigger_dac(spi_trigger_dac),
      .spi_done(spi_done),
      .spi_wr_en(spi_wr_en),
      .spi_data_out(spi_data_out),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .rd_ready(rd_ready),
      .busy(busy),
      .timeout_err(timeout_err),
      .rd_lost_err(rd_lost_err),
      .err_clr(err_clr)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to measure trigger spacing and timeout latency
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic flagFailure(input string name, input string detail);
      total++;
      bad++;
      $display("[TB] FAIL %s: %s", name, detail);
   endtask

   // Trigger monitor: every start pulse must match the oldest accepted command
   always @(negedge clk) begin
      logic [40:0] exp;
      if (!rst_n) begin
         hasPrev = 0;
      end else if (spi_trigger_sys && spi_trigger_dac) begin
         flagFailure("bothTriggers", "got sys=1 dac=1, expected at most one high");
      end else if (spi_trigger_sys || spi_trigger_dac) begin
         trigCount++;
         if (hasPrev) begin
            checkOutput("trigSpacingOk", 64'((cycleCnt - lastTrigCycle) >= MIN_SPACING), 64'd1);
         end
         hasPrev = 1;
         lastTrigCycle = cycleCnt;
         if (expTrigQ.size() == 0) begin
            $display("[TB] FAIL unexpectedTrigger: got trigger with data 0x%0h, expected none", spi_data_in);
            total++;
            bad++;
         end else begin
            exp = expTrigQ.pop_front();
            checkOutput("trigLine", spi_trigger_dac, exp[40]);
            checkOutput("trigData", spi_data_in, exp[39:0]);
         end
      end
   end

   // Readback monitor: each popped word must match the oldest expected word
   always @(negedge clk) begin
      if (rst_n && rd_valid && rd_ready) begin
         if (expRdQ.size() == 0) begin
            $display("[TB] FAIL unexpectedReadback: got 0x%0h, expected no word", rd_data);
            total++;
            bad++;
         end else begin
            checkOutput("rdData", rd_data, expRdQ.pop_front());
         end
      end
   end

   // Behavioural SPI controller: done after CTL_LAT cycles, readback one cycle later
   always @(negedge clk) begin
      if (!rst_n) begin
         ctlActive    = 0;
         spi_done     = 1'b0;
         spi_wr_en    = 1'b0;
         spi_data_out = '0;
      end else begin
         spi_done  = 1'b0;
         spi_wr_en = 1'b0;
         if (strayReq != strayAck) begin
            strayAck     = strayReq;
            spi_done     = 1'b1;
            spi_wr_en    = 1'b1;
            spi_data_out = 40'hDE_AD00_BEEF;
         end
         if (ctlActive) begin
            ctlCnt++;
            if (ctlNoDoneLat) begin
               if (ctlCnt > TIMEOUT + 4) ctlActive = 0;
            end else if (ctlCnt == CTL_LAT) begin
               spi_done = 1'b1;
               checkOutput("dataStable", spi_data_in, ctlHeld);
               if (ctlSameLat) begin
                  spi_wr_en    = 1'b1;
                  spi_data_out = ctlResp;
                  ctlActive    = 0;
               end
            end else if (ctlCnt == CTL_LAT + 1) begin
               spi_wr_en    = 1'b1;
               spi_data_out = ctlResp;
               ctlActive    = 0;
            end
         end
         if (spi_trigger_sys || spi_trigger_dac) begin
            ctlActive    = 1;
            ctlCnt       = 0;
            ctlHeld      = spi_data_in;
            ctlNoDoneLat = ctlNoDone;
            ctlSameLat   = ctlSame;
            ctlResp      = (ctlRespQ.size() > 0) ? ctlRespQ.pop_front() : '0;
         end
      end
   end

   // Push one command through the handshake and record what it should produce
   task automatic applyStimulus(input logic [39:0] data, input bit isDac, input bit rd, input logic [39:0] resp);
      int waitCnt = 0;
      bit accepted = 0;
      @(negedge clk);
      cmd_data   = data;
      cmd_is_dac = isDac;
      cmd_rd     = rd;
      cmd_valid  = 1'b1;
      while (!accepted && waitCnt < 3000) begin
         if (cmd_ready) begin
            @(posedge clk);
            accepted = 1;
         end else begin
            @(negedge clk);
            waitCnt++;
         end
      end
      if (accepted) begin
         expTrigQ.push_back({isDac, data});
         ctlRespQ.push_back(resp);
         if (rd && !ctlNoDone) expRdQ.push_back(resp);
      end else begin
         flagFailure("pushTimeout", "got cmd_ready stuck low, expected acceptance");
      end
      #1 cmd_valid = 1'b0;
   endtask

   task automatic setRdReady(input bit v);
      @(posedge clk);
      #1 rd_ready = v;
   endtask

   task automatic waitTrig(input int target);
      int n = 0;
      while (trigCount < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (trigCount < target) flagFailure("waitTrigTimeout", "got too few triggers, expected more");
   endtask

   task automatic waitIdle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(expTrigQ.size() == 0 && !busy && !ctlActive) && n < 4000);
      if (n >= 4000) flagFailure("waitIdleTimeout", "got sequencer still busy, expected idle");
      repeat (4) @(negedge clk);
   endtask

   // Directed test sequence
   initial begin
      int tStart;
      int n;
      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_data   = '0;
      cmd_is_dac = 1'b0;
      cmd_rd     = 1'b0;
      rd_ready   = 1'b0;
      err_clr    = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rstCmdReady", cmd_ready, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstRdValid", rd_valid, 0);
      checkOutput("rstTriggers", {spi_trigger_sys, spi_trigger_dac}, 0);
      checkOutput("rstSpiData", spi_data_in, 0);
      checkOutput("rstErrors", {timeout_err, rd_lost_err}, 0);
      rst_n = 1'b1;
      #1 checkOutput("cmdReadyBeforeEdge", cmd_ready, 0);
      @(negedge clk);
      checkOutput("cmdReadyAfterRelease", cmd_ready, 1);

      // Single readback transaction
      applyStimulus(40'hA5_0000_0001, 0, 1, 40'h12_3456_789A);
      waitIdle();
      checkOutput("singleTrigCount", trigCount, 1);
      checkOutput("singleRdValid", rd_valid, 1);
      checkOutput("singleRdData", rd_data, 40'h12_3456_789A);
      setRdReady(1);
      repeat (2) @(negedge clk);
      checkOutput("singleRdDrained", rd_valid, 0);
      setRdReady(0);

      // Readback FIFO full holds back the third readback command
      applyStimulus(40'h11_0000_0001, 1, 1, 40'h0A_0000_0001);
      applyStimulus(40'h22_0000_0002, 0, 1, 40'h0B_0000_0002);
      applyStimulus(40'h33_0000_0003, 1, 1, 40'h0C_0000_0003);
      waitTrig(3);
      repeat (150) @(negedge clk);
      checkOutput("thirdWithheld", trigCount, 3);
      checkOutput("withheldIdle", busy, 0);
      checkOutput("withheldRdValid", rd_valid, 1);
      checkOutput("withheldNoLost", rd_lost_err, 0);
      setRdReady(1);
      setRdReady(0);
      waitTrig(4);
      waitIdle();
      checkOutput("afterPopNoLost", rd_lost_err, 0);

      // Burst of five with the head held back fills the command FIFO
      applyStimulus(40'h44_0000_0004, 0, 1, 40'h0D_0000_0004);
      applyStimulus(40'h44_0000_0005, 1, 0, 40'h0D_0000_0005);
      applyStimulus(40'h44_0000_0006, 0, 0, 40'h0D_0000_0006);
      applyStimulus(40'h44_0000_0007, 1, 0, 40'h0D_0000_0007);
      checkOutput("cmdFullReady", cmd_ready, 0);
      checkOutput("burstNotIssued", trigCount, 4);
      fork
         applyStimulus(40'h44_0000_0008, 0, 0, 40'h0D_0000_0008);
         begin
            repeat (6) @(negedge clk);
            setRdReady(1);
         end
      join
      waitIdle();
      checkOutput("burstTrigCount", trigCount, 9);

      // Controller never answers: timeout, no readback, next command still runs
      ctlNoDone = 1;
      applyStimulus(40'h55_0000_0005, 0, 1, 40'h0E_0000_0005);
      applyStimulus(40'h66_0000_0006, 1, 0, 40'h0F_0000_0006);
      waitTrig(10);
      @(negedge clk);
      ctlNoDone = 0;
      tStart = lastTrigCycle;
      n = 0;
      while (!timeout_err && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("timeoutLatency", cycleCnt - tStart, TIMEOUT);
      checkOutput("timeoutNoLost", rd_lost_err, 0);
      waitIdle();
      checkOutput("timeoutNextIssued", trigCount, 11);
      checkOutput("timeoutSticky", timeout_err, 1);
      checkOutput("timeoutNoReadback", rd_valid, 0);
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      checkOutput("errClr", timeout_err, 0);

      // Stray controller pulses while idle are ignored
      strayReq++;
      repeat (4) @(negedge clk);
      checkOutput("strayBusy", busy, 0);
      checkOutput("strayRdValid", rd_valid, 0);

      // Done and readback in the same cycle
      ctlSame = 1;
      applyStimulus(40'h77_0000_0007, 1, 1, 40'h07_7777_7777);
      waitIdle();
      ctlSame = 0;
      checkOutput("sameCycleCount", trigCount, 12);

      // Reset in the middle of a transaction with commands queued
      setRdReady(0);
      applyStimulus(40'h88_0000_0008, 0, 1, 40'h08_8888_8888);
      applyStimulus(40'h99_0000_0009, 1, 0, 40'h09_9999_9999);
      applyStimulus(40'hAA_0000_000A, 0, 1, 40'h0A_AAAA_AAAA);
      waitTrig(13);
      repeat (10) @(negedge clk);
      checkOutput("preResetBusy", busy, 1);
      rst_n = 1'b0;
      expTrigQ.delete();
      expRdQ.delete();
      ctlRespQ.delete();
      #1;
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstTriggers", {spi_trigger_sys, spi_trigger_dac}, 0);
      checkOutput("midRstSpiData", spi_data_in, 0);
      checkOutput("midRstCmdReady", cmd_ready, 0);
      checkOutput("midRstRdValid", rd_valid, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      checkOutput("noTrigAfterReset", trigCount, 13);
      checkOutput("postResetIdle", busy, 0);
      setRdReady(1);
      applyStimulus(40'hBB_0000_000B, 1, 1, 40'h0B_BBBB_BBBB);
      waitIdle();
      checkOutput("postResetTrig", trigCount, 14);
      checkOutput("trigQueueDrained", expTrigQ.size(), 0);
      checkOutput("rdQueueDrained", expRdQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter CMD_DEPTH, default 4, giving command FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RD_DEPTH, default 2, giving readback FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, giving the minimum idle cycles between SPI transactions (1..15).
REQ-004 The block SHALL have parameter TIMEOUT, default 64, giving the maximum cycles from trigger to spi_done (8..255).
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 cmd_data  input  40  SPI word to shift out, MSB first.
REQ-008 cmd_is_dac  input  1  1 = DAC transaction, 0 = system-config transaction.
REQ-009 cmd_rd  input  1  1 = capture this transaction's readback word.
REQ-010 cmd_valid / cmd_ready  input / output  1 each  command handshake; a transfer occurs when both are high on a clock edge.
REQ-011 spi_data_in  output  40  word presented to the SPI controller.
REQ-012 spi_trigger_sys / spi_trigger_dac  output  1 each  single-cycle start pulses to the SPI controller.
REQ-013 spi_done / spi_wr_en / spi_data_out  input  1 / 1 / 40  controller completion pulse, readback-valid pulse, and readback word.
REQ-014 rd_data / rd_valid / rd_ready  output / output / input  40 / 1 / 1  readback FIFO head and handshake.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 timeout_err / rd_lost_err  output  1 each  sticky error flags.
REQ-017 err_clr  input  1  synchronous clear of both sticky error flags.

Function
REQ-018 cmd_ready SHALL equal "command FIFO not full"; a push into a full FIFO SHALL NOT occur.
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE, WAIT_WR, GAP.
REQ-020 IDLE SHALL go to ISSUE when the command FIFO is non-empty, except that a head entry with cmd_rd=1 SHALL wait in IDLE while the readback FIFO is full.
REQ-021 ISSUE SHALL last exactly one cycle and SHALL pop the head entry; during it, spi_trigger_dac or spi_trigger_sys (selected by cmd_is_dac) SHALL be high and spi_data_in SHALL equal the head cmd_data.
REQ-022 spi_data_in SHALL remain stable from ISSUE until the FSM leaves WAIT_WR or times out; both triggers SHALL never be high together.
REQ-023 WAIT_DONE SHALL go to WAIT_WR on spi_done=1.
REQ-024 WAIT_WR SHALL wait for spi_wr_en=1; on that cycle, if the entry's cmd_rd=1, spi_data_out SHALL be pushed to the readback FIFO; the FSM then SHALL enter GAP.
REQ-025 If spi_wr_en and spi_done occur together in WAIT_DONE, the FSM SHALL capture as in REQ-024 and go directly to GAP.
REQ-026 GAP SHALL last GAP_CYCLES cycles, then return to IDLE; a queued command SHALL be triggered no sooner than GAP_CYCLES+1 cycles after the spi_wr_en cycle.
REQ-027 A counter started at ISSUE SHALL, on reaching TIMEOUT in WAIT_DONE or WAIT_WR, set timeout_err, discard the transaction without a readback push, and enter GAP.
REQ-028 If a readback push would overflow (possible only through a simultaneous full condition), the word SHALL be dropped and rd_lost_err set.
REQ-029 rd_valid SHALL equal "readback FIFO not empty"; the head SHALL pop when rd_valid and rd_ready are both high; a simultaneous push and pop at full or empty SHALL be accepted with the count unchanged.
REQ-030 Stray spi_done or spi_wr_en pulses in IDLE or GAP SHALL be ignored.
REQ-031 err_clr SHALL clear the flags, except that a flag set condition in the same cycle SHALL win.
REQ-032 FIFO pointers SHALL wrap modulo depth, and occupancy SHALL be tracked with an extra pointer bit.

Reset
REQ-033 While rst_n=0: FSM=IDLE, both FIFOs empty, spi_data_in=0, both triggers=0, busy=0, rd_valid=0, both error flags=0, counters=0; cmd_ready SHALL be 0 during reset and SHALL become 1 on the first edge after release.
REQ-034 Reset asserted mid-transaction SHALL discard all queued and in-flight commands and readback data, with no trigger pulse after release until a new command is accepted.

Verification
REQ-035 Push one command {0xA5_0000_0001, is_dac=0, rd=1}; model a 40-cycle controller returning 0x12_3456_789A -> exactly one spi_trigger_sys pulse, spi_data_in held stable, and rd_data=0x12_3456_789A with rd_valid.
REQ-036 Push 5 commands back-to-back with CMD_DEPTH=4 -> cmd_ready low after the 4th accepted push (before the first ISSUE), all 5 issued in order, and trigger spacing at least 40+GAP_CYCLES+1 cycles.
REQ-037 Issue 3 rd=1 commands with rd_ready=0 and RD_DEPTH=2 -> third trigger withheld until one rd pop, and rd_lost_err remains 0.
REQ-038 Controller never asserts spi_done -> timeout_err=1 at TIMEOUT cycles after ISSUE, no readback push, next command issued afterwards; err_clr -> flag returns to 0.
REQ-039 Mixed is_dac=1/0 sequence -> each pulse on the correct trigger line, never both high at once.
REQ-040 Drive rst_n low during WAIT_DONE with 2 queued commands -> all outputs at reset values, and no trigger after release until a new push.
